// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: groups the dispatcher, CDB, query and commit/rollback signals of the
// reorder buffer into one bundle.
//   slave  modport - seen by the reorder buffer itself
//   master modport - seen by the surrounding pipeline (dispatcher, CDB, register file)
// Signals:
//   rdy                           global ready, low freezes the buffer
//   issue_valid/issue_rd/
//   issue_is_branch               allocation request from the dispatcher
//   rob_full/alloc_id             allocation status back to the dispatcher
//   cdb_valid/cdb_id/cdb_value/
//   cdb_mispredict/cdb_target_pc  result broadcast
//   query_id*/query_ready*/
//   query_value*                  operand lookup by ROB ID
//   rob_has_res/result_to_reg/
//   regidx_to_reg/regalias_to_reg register-file commit port
//   rollback_signal/rollback_pc   flush pulse and fetch redirect
interface reorder_buffer_if #(
    parameter int unsigned ROB_ID_W = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 5
);
    logic                rdy;
    logic                issue_valid;
    logic [REG_W-1:0]    issue_rd;
    logic                issue_is_branch;
    logic                rob_full;
    logic [ROB_ID_W-1:0] alloc_id;
    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_id;
    logic [DATA_W-1:0]   cdb_value;
    logic                cdb_mispredict;
    logic [DATA_W-1:0]   cdb_target_pc;
    logic [ROB_ID_W-1:0] query_id1;
    logic [ROB_ID_W-1:0] query_id2;
    logic                query_ready1;
    logic                query_ready2;
    logic [DATA_W-1:0]   query_value1;
    logic [DATA_W-1:0]   query_value2;
    logic                rob_has_res;
    logic [DATA_W-1:0]   result_to_reg;
    logic [REG_W-1:0]    regidx_to_reg;
    logic [ROB_ID_W-1:0] regalias_to_reg;
    logic                rollback_signal;
    logic [DATA_W-1:0]   rollback_pc;

    modport slave (
        input  rdy, issue_valid, issue_rd, issue_is_branch,
        input  cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target_pc,
        input  query_id1, query_id2,
        output rob_full, alloc_id,
        output query_ready1, query_ready2, query_value1, query_value2,
        output rob_has_res, result_to_reg, regidx_to_reg, regalias_to_reg,
        output rollback_signal, rollback_pc
    );

    modport master (
        output rdy, issue_valid, issue_rd, issue_is_branch,
        output cdb_valid, cdb_id, cdb_value, cdb_mispredict, cdb_target_pc,
        output query_id1, query_id2,
        input  rob_full, alloc_id,
        input  query_ready1, query_ready2, query_value1, query_value2,
        input  rob_has_res, result_to_reg, regidx_to_reg, regalias_to_reg,
        input  rollback_signal, rollback_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer. Allocates ROB IDs at dispatch, captures
// CDB results, retires one entry per cycle in program order and raises a one-cycle rollback
// when a mispredicted branch reaches the head.
// Ports:
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  reorder_buffer_if.slave (dispatch, CDB, query, commit and rollback signals)
// ROB IDs are slot index + 1; ID 0 means "no alias" and never matches an entry.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE = 16,
    parameter int unsigned ROB_ID_W = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_W    = 5
) (
    input logic             clk,
    input logic             rst,
    reorder_buffer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(ROB_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage
    logic [ROB_SIZE-1:0] busy_q, busy_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    logic [ROB_SIZE-1:0] br_q, br_d;
    logic [ROB_SIZE-1:0] mis_q, mis_d;
    logic [REG_W-1:0]    rd_q    [ROB_SIZE];
    logic [REG_W-1:0]    rd_d    [ROB_SIZE];
    logic [DATA_W-1:0]   value_q [ROB_SIZE];
    logic [DATA_W-1:0]   value_d [ROB_SIZE];
    logic [DATA_W-1:0]   tpc_q   [ROB_SIZE];
    logic [DATA_W-1:0]   tpc_d   [ROB_SIZE];

    // Pointers
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Registered outputs
    logic                has_res_q, has_res_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic [REG_W-1:0]    regidx_q, regidx_d;
    logic [ROB_ID_W-1:0] regalias_q, regalias_d;
    logic                rollback_q, rollback_d;
    logic [DATA_W-1:0]   rollback_pc_q, rollback_pc_d;

    logic             full;
    logic             accept;
    logic             do_alloc;
    logic             do_cdb;
    logic             do_commit;
    logic             do_rollback;
    logic [PTR_W-1:0] cdb_slot;

    assign full     = (count_q == CNT_W'(ROB_SIZE));
    // Inputs are ignored while frozen and during the rollback pulse cycle.
    assign accept   = bus.rdy && !rollback_q;
    assign cdb_slot = PTR_W'(bus.cdb_id - ROB_ID_W'(1));

    // Commit looks only at registered state, so a CDB write lands one edge before it can retire.
    assign do_commit   = bus.rdy && busy_q[head_q] && ready_q[head_q];
    assign do_rollback = do_commit && br_q[head_q] && mis_q[head_q];
    assign do_alloc    = accept && !do_rollback && bus.issue_valid && !full;
    assign do_cdb      = accept && !do_rollback && bus.cdb_valid &&
                         (bus.cdb_id != '0) && (bus.cdb_id <= ROB_ID_W'(ROB_SIZE));

    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        br_d          = br_q;
        mis_d         = mis_q;
        rd_d          = rd_q;
        value_d       = value_q;
        tpc_d         = tpc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        // Pulses hold their value while frozen, otherwise they drop after one cycle.
        has_res_d     = bus.rdy ? 1'b0 : has_res_q;
        rollback_d    = bus.rdy ? 1'b0 : rollback_q;
        result_d      = result_q;
        regidx_d      = regidx_q;
        regalias_d    = regalias_q;
        rollback_pc_d = rollback_pc_q;

        // Results for slots that are not in flight are stale and dropped.
        if (do_cdb && busy_q[cdb_slot]) begin
            ready_d[cdb_slot] = 1'b1;
            value_d[cdb_slot] = bus.cdb_value;
            mis_d[cdb_slot]   = bus.cdb_mispredict;
            tpc_d[cdb_slot]   = bus.cdb_target_pc;
        end

        if (do_alloc) begin
            busy_d[tail_q]  = 1'b1;
            ready_d[tail_q] = 1'b0;
            mis_d[tail_q]   = 1'b0;
            br_d[tail_q]    = bus.issue_is_branch;
            rd_d[tail_q]    = bus.issue_rd;
            tail_d          = tail_q + PTR_W'(1);
        end

        if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
            if (!br_q[head_q]) begin
                has_res_d  = 1'b1;
                result_d   = value_q[head_q];
                regidx_d   = rd_q[head_q];
                regalias_d = ROB_ID_W'(head_q) + ROB_ID_W'(1);
            end
        end

        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_commit);

        // Mispredict flushes everything younger; the branch itself has just retired.
        if (do_rollback) begin
            rollback_d    = 1'b1;
            rollback_pc_d = tpc_q[head_q];
            busy_d        = '0;
            ready_d       = '0;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q        <= '0;
            ready_q       <= '0;
            br_q          <= '0;
            mis_q         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]    <= '0;
                value_q[i] <= '0;
                tpc_q[i]   <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            has_res_q     <= 1'b0;
            result_q      <= '0;
            regidx_q      <= '0;
            regalias_q    <= '0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            br_q          <= br_d;
            mis_q         <= mis_d;
            rd_q          <= rd_d;
            value_q       <= value_d;
            tpc_q         <= tpc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            has_res_q     <= has_res_d;
            result_q      <= result_d;
            regidx_q      <= regidx_d;
            regalias_q    <= regalias_d;
            rollback_q    <= rollback_d;
            rollback_pc_q <= rollback_pc_d;
        end
    end

    // Operand queries; a same-cycle CDB broadcast bypasses the entry storage.
    logic [PTR_W-1:0] q1_slot;
    logic [PTR_W-1:0] q2_slot;
    logic             q1_ok;
    logic             q2_ok;

    assign q1_slot = PTR_W'(bus.query_id1 - ROB_ID_W'(1));
    assign q2_slot = PTR_W'(bus.query_id2 - ROB_ID_W'(1));
    assign q1_ok   = (bus.query_id1 != '0) && (bus.query_id1 <= ROB_ID_W'(ROB_SIZE));
    assign q2_ok   = (bus.query_id2 != '0) && (bus.query_id2 <= ROB_ID_W'(ROB_SIZE));

    always_comb begin
        bus.query_ready1 = 1'b0;
        bus.query_value1 = '0;
        bus.query_ready2 = 1'b0;
        bus.query_value2 = '0;
        if (q1_ok) begin
            if (bus.cdb_valid && (bus.cdb_id == bus.query_id1)) begin
                bus.query_ready1 = 1'b1;
                bus.query_value1 = bus.cdb_value;
            end else if (ready_q[q1_slot]) begin
                bus.query_ready1 = 1'b1;
                bus.query_value1 = value_q[q1_slot];
            end
        end
        if (q2_ok) begin
            if (bus.cdb_valid && (bus.cdb_id == bus.query_id2)) begin
                bus.query_ready2 = 1'b1;
                bus.query_value2 = bus.cdb_value;
            end else if (ready_q[q2_slot]) begin
                bus.query_ready2 = 1'b1;
                bus.query_value2 = value_q[q2_slot];
            end
        end
    end

    assign bus.rob_full        = full;
    assign bus.alloc_id        = ROB_ID_W'(tail_q) + ROB_ID_W'(1);
    assign bus.rob_has_res     = has_res_q;
    assign bus.result_to_reg   = result_q;
    assign bus.regidx_to_reg   = regidx_q;
    assign bus.regalias_to_reg = regalias_q;
    assign bus.rollback_signal = rollback_q;
    assign bus.rollback_pc     = rollback_pc_q;
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between the dispatcher/CDB and the register file.
- Allocates ROB IDs for renaming and captures results broadcast on the CDB.
- Retires one entry per cycle in program order through the register-file commit port.
- Raises a one-cycle rollback when a mispredicted branch reaches the head.

Parameters:
ROB_SIZE, 16, number of entries (power of two)
ROB_ID_W, 5, ROB ID width; ID = slot index + 1, ID 0 reserved as "no alias"
DATA_W, 32, data/PC width
REG_W, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low = freeze all state
issue_valid  in  1  dispatcher allocates an entry this cycle
issue_rd  in  REG_W  destination register (0 = none)
issue_is_branch  in  1  entry is a branch
rob_full  out  1  no free entry (combinational from count)
alloc_id  out  ROB_ID_W  ID the next allocation receives (tail+1)
cdb_valid  in  1  execution result broadcast
cdb_id  in  ROB_ID_W  ROB ID of the result
cdb_value  in  DATA_W  result value
cdb_mispredict  in  1  branch resolved opposite to prediction
cdb_target_pc  in  DATA_W  correct PC for a mispredicted branch
query_id1, query_id2  in  ROB_ID_W  operand aliases from the dispatcher
query_ready1, query_ready2  out  1  queried entry has a value
query_value1, query_value2  out  DATA_W  value of the queried entry
rob_has_res  out  1  commit strobe to the register file
result_to_reg  out  DATA_W  committed value
regidx_to_reg  out  REG_W  committed rd
regalias_to_reg  out  ROB_ID_W  committed entry ID
rollback_signal  out  1  flush pulse to all stages
rollback_pc  out  DATA_W  fetch redirect target

Behaviour:
- Reset (rst=0, async):
  - head=tail=count=0 and all entry valid/ready bits cleared.
  - rob_has_res=0, rollback_signal=0; result_to_reg, regidx_to_reg, regalias_to_reg and rollback_pc all 0.
- rdy=0: no state or output register changes.
- Entry fields: busy, ready, rd, is_branch, value, mispredict, target_pc.
- Allocate (issue_valid && !rob_full):
  - Write slot tail with busy=1, ready=0, rd and is_branch from the issue ports.
  - tail advances modulo ROB_SIZE.
  - issue_valid while full is ignored; this is an illegal upstream condition and is flagged by the bench.
- Write-back (cdb_valid): slot cdb_id-1 gets ready=1 and captures value, mispredict and target_pc. A CDB write to a non-busy slot is ignored.
- Commit:
  - Condition: the head slot is busy and ready at a clock edge.
  - At that edge the head slot is freed, head advances, and registered outputs are driven for exactly one cycle:
    - rob_has_res=1
    - result_to_reg = value
    - regidx_to_reg = rd
    - regalias_to_reg = head+1
  - rd=0 is still presented; the register file discards it.
  - Latency: a CDB write at edge N commits at edge N+1 at the earliest. At most one commit per cycle.
- Branches: a branch commits with rob_has_res=0.
- Mispredicted branch at head:
  - At the commit edge: rollback_signal=1 for one cycle, rollback_pc = target_pc.
  - All entries cleared; head=tail=count=0.
  - issue_valid and cdb_valid in that same cycle are dropped.
- While rollback_signal is high: issue_valid and cdb_valid are ignored; the following cycle is normal.
- Count: next = count + alloc − commit. Allocation and commit in the same cycle are legal even when count==ROB_SIZE−1.
- rob_full = (count==ROB_SIZE). With a commit pending the buffer still reports full; allocation is not speculated.
- Query (combinational):
  - query_ready = slot ready, OR (cdb_valid && cdb_id == query_id); the CDB value bypasses.
  - query_id=0 returns ready=0 and value=0.
- Pointer wrap: slot ROB_SIZE−1 is followed by slot 0. IDs wrap 16→1.

Test Plan:
- Reset, then issue 3 entries rd=1,2,3 → alloc_id steps 1,2,3,4; CDB writes 0xA/0xB/0xC out of order (ids 3,1,2) → commits in order rd1=0xB, rd2=0xC, rd3=0xA on consecutive cycles, each with rob_has_res=1.
- Fill 16 entries → rob_full=1. 17th issue_valid causes no state change. Complete id 1 → commit, rob_full=0, then the next alloc_id=1 (wrap).
- Branch at id 2 with cdb_mispredict=1, target 0x1040, with younger ids 3–5 ready → id 1 commits, then rollback_signal pulses one cycle with rollback_pc=0x1040. Ids 3–5 never commit; after rollback alloc_id=1 and rob_full=0.
- query_id1=4 in the same cycle as a CDB write of id 4 with 0x55 → query_ready1=1 and query_value1=0x55 combinationally. query_id1=0 → ready 0.
- Hold rdy=0 for 3 cycles with a ready head → no commit and no pointer motion; commit occurs on the first cycle after rdy returns to 1.
- Assert rst low mid-stream, asynchronously between edges → rob_has_res and rollback_signal go to 0 immediately. After release, alloc_id=1 and rob_full=0.
